// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for rename/dispatch.
// Dispatch pops from the head and commit pushes at the tail; a flush makes the list full again.
module phys_free_list #(
    parameter int PHYS_REG_BITS = 6,
    parameter int ARCH_REGS     = 32,
    parameter int DEPTH         = 2**PHYS_REG_BITS - ARCH_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    output logic [PHYS_REG_BITS-1:0] alloc_preg,
    output logic                     alloc_ack,
    input  logic                     free_we,
    input  logic [PHYS_REG_BITS-1:0] free_preg,
    input  logic                     flush,
    output logic                     empty,
    output logic                     full,
    output logic [PHYS_REG_BITS:0]   count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] PTR_ONE  = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0] PTR_WRAP = (PTR_BITS+1)'(1) << PTR_BITS;

    logic [PHYS_REG_BITS-1:0] entries [DEPTH];
    logic [PTR_BITS:0]        head, tail, head_next, tail_next, used;
    logic                     do_free;

    always_comb begin
        empty      = (head == tail);
        full       = (head[PTR_BITS-1:0] == tail[PTR_BITS-1:0]) &&
                     (head[PTR_BITS] != tail[PTR_BITS]);
        used       = tail - head;
        count      = {{(PHYS_REG_BITS-PTR_BITS){1'b0}}, used};
        alloc_preg = entries[head[PTR_BITS-1:0]];
        // Gated by rst so a held request shows no ack while reset is asserted.
        alloc_ack  = rst && alloc_req && !empty && !flush;
        do_free    = free_we && (free_preg != '0) && !full;
        tail_next  = do_free ? tail + PTR_ONE : tail;
        // Flush: the DEPTH slots ending at the new tail hold exactly the non-committed registers.
        if (flush) begin
            head_next = tail_next ^ PTR_WRAP;
        end else begin
            head_next = alloc_ack ? head + PTR_ONE : head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= PTR_WRAP;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            if (do_free) begin
                entries[tail[PTR_BITS-1:0]] <= free_preg;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(free_we && (free_preg != '0) && full))
                else $warning("free of p%0d while free list full, dropped", free_preg);
            assert (count <= (PHYS_REG_BITS+1)'(DEPTH))
                else $error("free list count %0d exceeds capacity", count);
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = i + 1; j < DEPTH; j++) begin
                    if (j < int'(count)) begin
                        assert (entries[head[PTR_BITS-1:0] + PTR_BITS'(i)] !=
                                entries[head[PTR_BITS-1:0] + PTR_BITS'(j)])
                            else $error("duplicate p%0d in free list",
                                        entries[head[PTR_BITS-1:0] + PTR_BITS'(i)]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus a randomized rename/commit/flush run,
// all compared against a queue-based model of the free list.
module tb_phys_free_list;

    localparam int PRB   = 6;
    localparam int AR    = 32;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           alloc_req = 1'b0;
    logic [PRB-1:0] alloc_preg;
    logic           alloc_ack;
    logic           free_we = 1'b0;
    logic [PRB-1:0] free_preg = '0;
    logic           flush = 1'b0;
    logic           empty;
    logic           full;
    logic [PRB:0]   count;

    phys_free_list #(.PHYS_REG_BITS(PRB), .ARCH_REGS(AR)) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_preg (alloc_preg),
        .alloc_ack  (alloc_ack),
        .free_we    (free_we),
        .free_preg  (free_preg),
        .flush      (flush),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: fl is the free list in FIFO order; hist holds the last DEPTH values ever enqueued,
    // which is what a flush restores.
    int fl[$];
    int hist[$];

    typedef struct {int arch; int preg;} inflight_t;
    int        rrat[AR];
    inflight_t infl[$];

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        hist.delete();
        infl.delete();
        for (int i = 0; i < DEPTH; i++) begin
            fl.push_back(AR + i);
            hist.push_back(AR + i);
        end
        for (int a = 0; a < AR; a++) rrat[a] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_req = 1'b0;
        free_we   = 1'b0;
        free_preg = '0;
        flush     = 1'b0;
        rst       = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input bit req, input bit fwe, input int fp, input bit fl_in,
                        output bit ack, output int got);
        bit was_full;
        @(negedge clk);
        alloc_req = req;
        free_we   = fwe;
        free_preg = PRB'(fp);
        flush     = fl_in;
        #1;
        was_full = (fl.size() == DEPTH);
        ack      = req && (fl.size() > 0) && !fl_in;
        chk("empty", empty, int'(fl.size() == 0));
        chk("full", full, int'(was_full));
        chk("count", count, fl.size());
        chk("alloc_ack", alloc_ack, int'(ack));
        if (fl.size() > 0) chk("alloc_preg", alloc_preg, fl[0]);
        got = -1;
        if (ack) got = fl.pop_front();
        if (fwe && fp != 0 && !was_full) begin
            fl.push_back(fp);
            hist.push_back(fp);
            if (hist.size() > DEPTH) void'(hist.pop_front());
        end
        if (fl_in) fl = hist;
    endtask

    initial begin
        bit ack;
        int got;
        int ah[$];
        int fp;
        int arch;
        bit req, cmt, fls;
        inflight_t e;

        // Drain the full list, then one more request must fail.
        do_reset();
        chk("reset_preg", alloc_preg, AR);
        chk("reset_count", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, ack, got);
        step(1, 0, 0, 0, ack, got);
        chk("empty_after_drain", empty, 1);

        // Alloc fails on empty while a same-cycle free enqueues.
        step(1, 1, 5, 0, ack, got);
        step(1, 0, 0, 0, ack, got);
        chk("refill_got", got, 5);
        step(0, 0, 0, 0, ack, got);

        // Steady state at 10 free entries, recycling registers allocated 10 cycles earlier.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(1, 0, 0, 0, ack, got);
            ah.push_back(got);
        end
        for (int i = 0; i < 100; i++) begin
            fp = ah[ah.size() - 10];
            step(1, 1, fp, 0, ack, got);
            ah.push_back(got);
        end
        step(0, 0, 0, 0, ack, got);
        chk("steady_count", count, 10);

        // Speculative allocs, three commit frees, then flush.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, ack, got);
        for (int i = 1; i <= 3; i++) step(0, 1, i, 0, ack, got);
        step(1, 0, 0, 1, ack, got);
        step(0, 0, 0, 0, ack, got);
        chk("flush_full", full, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, ack, got);
        chk("flush_last", got, 3);
        step(0, 0, 0, 0, ack, got);

        // p0 frees are dropped; a free while full is dropped.
        do_reset();
        step(0, 1, 0, 0, ack, got);
        step(0, 1, 40, 0, ack, got);
        step(1, 0, 0, 0, ack, got);
        step(0, 1, 0, 0, ack, got);
        step(0, 0, 0, 0, ack, got);
        chk("drop_count", count, DEPTH - 1);

        // Asynchronous reset mid-cycle after 12 allocations.
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, ack, got);
        @(negedge clk);
        alloc_req = 1'b1;
        free_we   = 1'b0;
        flush     = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_preg", alloc_preg, AR);
        chk("arst_ack", alloc_ack, 0);
        chk("arst_full", full, 1);
        chk("arst_empty", empty, 0);
        chk("arst_count", count, DEPTH);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        alloc_req = 1'b0;
        step(1, 0, 0, 0, ack, got);
        chk("arst_first_alloc", got, AR);

        // Random rename / commit / flush traffic that respects the renamer protocol.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 3) != 0);
            cmt  = (infl.size() > 0) && ($urandom_range(0, 2) == 0);
            fls  = ($urandom_range(0, 49) == 0);
            arch = $urandom_range(1, AR - 1);
            fp   = 0;
            if (cmt) begin
                e = infl.pop_front();
                fp = rrat[e.arch];
                rrat[e.arch] = e.preg;
            end
            step(req, cmt, fp, fls, ack, got);
            if (fls) infl.delete();
            else if (ack) infl.push_back('{arch: arch, preg: got});
        end
        step(0, 0, 0, 0, ack, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
